mod_op_scheduler: RTL and testbench
===================================

# mod_op_scheduler

Sequencer and two-channel arbiter for the shared modular adder/subtractor datapath, which comprises the first stage, the second stage and the final select. It accepts operation requests from two independent requesters and grants them round-robin. It drives operands and the add/subtract select into the datapath, waits out the datapath latency, and returns the modular result with the requester ID over a valid/ready response port. One operation is in flight at a time. Operands outside the modulus range are rejected locally, without using the datapath.

## Interface
Parameters:
- M, 4'b0000, modulus offset; modulus N = 16 − M; forwarded unchanged to the datapath configuration.
- LAT, 2, datapath latency in cycles from dp_issue to a valid dp_result; legal range 1..7.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  channel 0 request valid.
- req0_ready  out  1  channel 0 accepted this cycle when high with req0_valid.
- req0_x, req0_y  in  4  channel 0 operands.
- req0_sub  in  1  channel 0 operation: 0 = x+y mod N, 1 = x−y mod N.
- req1_valid, req1_ready, req1_x, req1_y, req1_sub: same as channel 0, for channel 1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_id  out  1  channel that issued the request.
- rsp_data  out  4  modular result; 0 when rsp_err = 1.
- rsp_err  out  1  operand out of range (x ≥ N or y ≥ N).
- dp_issue  out  1  one-cycle strobe marking a new datapath operation.
- dp_x, dp_y  out  4  registered datapath operands.
- dp_s  out  1  datapath subtract select; carries the latched req_sub.
- dp_result  in  4  datapath modular result, valid LAT cycles after dp_issue.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Grant is computed combinationally in IDLE:
  - Only one reqN_valid high: grant that channel.
  - Both high: grant the channel ≠ last_served.
  - req_ready is high only in IDLE and only for the granted channel. Both ready signals are never high together.
- Acceptance (IDLE, valid & ready):
  - Latch x, y, sub into dp_x, dp_y and dp_s, and the channel into rsp_id.
  - Compute err = (x ≥ N) | (y ≥ N) using an unsigned 4-bit compare against 5-bit N.
- IDLE → RESP when err: rsp_data = 0, rsp_err = 1, dp_issue stays low.
- IDLE → ISSUE when no err.
- ISSUE: dp_issue = 1 for exactly this cycle. Load wait counter with LAT. → WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter reaches 1, capture dp_result into rsp_data, clear rsp_err, and → RESP.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_data and rsp_err are stable.
  - Hold until rsp_ready. On the handshake: last_served ← rsp_id, rsp_valid drops, → IDLE.
- dp_x, dp_y and dp_s hold their values from acceptance until the next acceptance. The datapath sees stable operands for the entire operation.
- rsp_ready is ignored while rsp_valid is low.
- dp_result is ignored outside the capture cycle.
- A requester may drop valid before it is accepted. The scheduler only samples valid in IDLE, and there is no penalty.
- No request is accepted while in ISSUE, WAIT or RESP; ready is low in those states.

## Timing
- Reset values: req0_ready = req1_ready = 0 during reset; rsp_valid = 0; rsp_id = 0; rsp_data = 0; rsp_err = 0; dp_issue = 0; dp_x = dp_y = 0; dp_s = 0; last_served = 1, so channel 0 wins the first tie.
- Reset mid-operation in any state: return to IDLE the next cycle. The in-flight result is discarded and no response is produced.
- Valid operation accepted at edge T:
  - dp_issue is high in cycle T+1.
  - dp_result is sampled at the end of cycle T+1+LAT.
  - rsp_valid rises in cycle T+2+LAT.
- Error operation accepted at edge T: rsp_valid rises in cycle T+1.
- Back-to-back: the earliest next acceptance is the cycle after the response handshake. Minimum period is LAT+3 cycles when rsp_ready is held high.
- Back-pressure: rsp_valid and its payload stay constant for any number of cycles while rsp_ready is low.

## Test plan
- M=3 (N=13), LAT=2. ch0 add x=9, y=7.
  - Required: dp_issue one cycle after accept; dp_x=9, dp_y=7, dp_s=0.
  - Required: rsp_valid 4 cycles after accept with rsp_data=3, rsp_id=0, rsp_err=0.
- M=3. ch1 subtract x=2, y=5.
  - Required: dp_s=1; rsp_data=10, rsp_id=1.
  - Then ch1 x=0, y=0 subtract: rsp_data=0.
- M=3. ch0 add x=13, y=1.
  - Required: dp_issue never asserts; rsp_valid the next cycle with rsp_err=1, rsp_data=0.
  - Repeat with y=15: same required response.
- M=0, both channels hold valid continuously for 4 operations.
  - Required: grants alternate 0, 1, 0, 1; req0_ready and req1_ready are never high together.
  - Required: each rsp_id matches its granted channel.
- LAT=2. rsp_ready held low 5 cycles after rsp_valid rises.
  - Required: payload stable throughout; no new accept.
  - Required: accept on the first IDLE cycle after the handshake.
- Assert rst during WAIT.
  - Required: all outputs at reset values next cycle; no rsp_valid from the aborted operation.
  - Required: a new ch1 request afterwards completes normally.

Source files
------------

// File: rtl/mod_op_scheduler.sv
// Round-robin front end for the shared modular add/sub datapath. One operation is
// in flight at a time. Operands outside the modulus range are answered locally.
module mod_op_scheduler #(
  parameter logic [3:0] M   = 4'b0000,
  parameter int         LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_x,
  input  logic [3:0] req0_y,
  input  logic       req0_sub,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_x,
  input  logic [3:0] req1_y,
  input  logic       req1_sub,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_data,
  output logic       rsp_err,
  output logic       dp_issue,
  output logic [3:0] dp_x,
  output logic [3:0] dp_y,
  output logic       dp_s,
  input  logic [3:0] dp_result
);
  localparam logic [4:0] N     = 5'd16 - {1'b0, M};
  localparam logic [2:0] LAT_C = 3'(LAT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_next;
  logic       r_last;
  logic       r_id;
  logic       r_err;
  logic [3:0] r_data;
  logic [3:0] r_dp_x;
  logic [3:0] r_dp_y;
  logic       r_dp_s;

  logic [1:0] w_valid;
  logic [1:0] w_grant;
  logic [1:0] w_ready;
  logic       w_accept;
  logic       w_sel;
  logic [3:0] w_acc_x;
  logic [3:0] w_acc_y;
  logic       w_acc_sub;
  logic       w_err;
  logic       w_capture;
  logic       w_handshake;

  assign w_valid = {req1_valid, req0_valid};

  // On a tie the channel that was not served last wins.
  always_comb begin
    w_grant = 2'b00;
    if (r_state == S_IDLE) begin
      case (w_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign w_ready[gi] = w_grant[gi] & ~rst;
    end
  endgenerate

  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];

  assign w_accept  = |(w_ready & w_valid);
  assign w_sel     = w_grant[1];
  assign w_acc_x   = w_sel ? req1_x   : req0_x;
  assign w_acc_y   = w_sel ? req1_y   : req0_y;
  assign w_acc_sub = w_sel ? req1_sub : req0_sub;
  assign w_err     = ({1'b0, w_acc_x} >= N) | ({1'b0, w_acc_y} >= N);

  assign w_capture   = (r_state == S_WAIT) && (r_cnt == 3'd1);
  assign w_handshake = (r_state == S_RESP) && rsp_ready;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_err ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_next   = LAT_C;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Operands stay frozen from acceptance so the datapath sees them throughout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_x <= 4'd0;
      r_dp_y <= 4'd0;
      r_dp_s <= 1'b0;
      r_id   <= 1'b0;
      r_err  <= 1'b0;
      r_data <= 4'd0;
    end else if (w_accept) begin
      r_dp_x <= w_acc_x;
      r_dp_y <= w_acc_y;
      r_dp_s <= w_acc_sub;
      r_id   <= w_sel;
      r_err  <= w_err;
      r_data <= 4'd0;
    end else if (w_capture) begin
      r_data <= dp_result;
      r_err  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_handshake) begin
      r_last <= r_id;
    end
  end

  assign dp_issue  = (r_state == S_ISSUE) & ~rst;
  assign rsp_valid = (r_state == S_RESP) & ~rst;
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;
  assign dp_x      = r_dp_x;
  assign dp_y      = r_dp_y;
  assign dp_s      = r_dp_s;
endmodule

// File: tb/tb_mod_op_scheduler.sv
// Bench for mod_op_scheduler: instance 0 (N=13, LAT=2) and instance 1 (N=16, LAT=5)
// run against a timestamp-based transaction model plus a datapath stub.
module tb_mod_op_scheduler;
  logic       clk;
  logic [1:0] rst_b;
  logic       v0 [2];
  logic       v1 [2];
  logic [3:0] x0 [2];
  logic [3:0] y0 [2];
  logic [3:0] x1 [2];
  logic [3:0] y1 [2];
  logic       s0 [2];
  logic       s1 [2];
  logic       rrdy [2];
  logic [3:0] dpr [2];
  logic       r0 [2];
  logic       r1 [2];
  logic       rv [2];
  logic       rid [2];
  logic       rerr [2];
  logic       iss [2];
  logic       ds [2];
  logic [3:0] rdat [2];
  logic [3:0] dx [2];
  logic [3:0] dy [2];

  int cyc = 0;
  int n_vec = 0;
  int n_mis = 0;

  // Model state: an operation is described by when it issues and when it responds.
  int m_busy [2];
  int m_last [2];
  int m_issue [2];
  int m_resp [2];
  int m_id [2];
  int m_data [2];
  int m_err [2];
  int m_x [2];
  int m_y [2];
  int m_s [2];
  int due [2];
  int dval [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      mod_op_scheduler #(
        .M  (gi == 0 ? 4'd3 : 4'd0),
        .LAT(gi == 0 ? 2 : 5)
      ) u_dut (
        .clk       (clk),
        .rst       (rst_b[gi]),
        .req0_valid(v0[gi]),
        .req0_ready(r0[gi]),
        .req0_x    (x0[gi]),
        .req0_y    (y0[gi]),
        .req0_sub  (s0[gi]),
        .req1_valid(v1[gi]),
        .req1_ready(r1[gi]),
        .req1_x    (x1[gi]),
        .req1_y    (y1[gi]),
        .req1_sub  (s1[gi]),
        .rsp_valid (rv[gi]),
        .rsp_ready (rrdy[gi]),
        .rsp_id    (rid[gi]),
        .rsp_data  (rdat[gi]),
        .rsp_err   (rerr[gi]),
        .dp_issue  (iss[gi]),
        .dp_x      (dx[gi]),
        .dp_y      (dy[gi]),
        .dp_s      (ds[gi]),
        .dp_result (dpr[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 5;
  endfunction

  function automatic int n_of(input int k);
    return (k == 0) ? 13 : 16;
  endfunction

  function automatic int mres(input int x, input int y, input int s, input int n);
    if (s != 0) return (((x - y) % n) + n) % n;
    return (x + y) % n;
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d", name, k, cyc, act, exp);
    end
  endtask

  task automatic step(input int k);
    int c;
    int g0;
    int g1;
    int exp_v;
    c = cyc;
    if (rst_b[k]) begin
      chk("ready0_in_reset", k, r0[k], 0);
      chk("ready1_in_reset", k, r1[k], 0);
      m_busy[k] = 0; m_last[k] = 1; m_issue[k] = -1; m_resp[k] = -1;
      m_id[k] = 0; m_data[k] = 0; m_err[k] = 0;
      m_x[k] = 0; m_y[k] = 0; m_s[k] = 0;
      due[k] = -1; dval[k] = 0;
      dpr[k] = 4'($urandom);
    end else begin
      g0 = 0; g1 = 0;
      if (m_busy[k] == 0) begin
        if (v0[k] && v1[k]) begin
          if (m_last[k] == 1) g0 = 1; else g1 = 1;
        end else if (v0[k]) g0 = 1;
        else if (v1[k]) g1 = 1;
      end
      chk("req0_ready", k, r0[k], g0);
      chk("req1_ready", k, r1[k], g1);
      chk("ready_exclusive", k, r0[k] & r1[k], 0);
      chk("dp_issue", k, iss[k], (m_busy[k] != 0 && c == m_issue[k]) ? 1 : 0);
      exp_v = (m_busy[k] != 0 && c >= m_resp[k]) ? 1 : 0;
      chk("rsp_valid", k, rv[k], exp_v);
      if (exp_v != 0) begin
        chk("rsp_id", k, rid[k], m_id[k]);
        chk("rsp_data", k, rdat[k], m_data[k]);
        chk("rsp_err", k, rerr[k], m_err[k]);
      end
      chk("dp_x", k, dx[k], m_x[k]);
      chk("dp_y", k, dy[k], m_y[k]);
      chk("dp_s", k, ds[k], m_s[k]);

      // Datapath stub: correct result only in the capture cycle, wrong otherwise.
      if (iss[k]) begin
        due[k]  = c + lat_of(k);
        dval[k] = mres(dx[k], dy[k], ds[k], n_of(k));
      end
      if (c == due[k]) dpr[k] = 4'(dval[k]);
      else dpr[k] = 4'(dval[k]) ^ 4'($urandom_range(1, 15));

      if (g0 != 0 || g1 != 0) begin
        m_busy[k] = 1;
        m_id[k]   = g1;
        m_x[k]    = g1 ? int'(x1[k]) : int'(x0[k]);
        m_y[k]    = g1 ? int'(y1[k]) : int'(y0[k]);
        m_s[k]    = g1 ? int'(s1[k]) : int'(s0[k]);
        if (m_x[k] >= n_of(k) || m_y[k] >= n_of(k)) begin
          m_err[k] = 1; m_data[k] = 0; m_issue[k] = -1; m_resp[k] = c + 1;
        end else begin
          m_err[k]   = 0;
          m_data[k]  = mres(m_x[k], m_y[k], m_s[k], n_of(k));
          m_issue[k] = c + 1;
          m_resp[k]  = c + 2 + lat_of(k);
        end
      end else if (exp_v != 0 && rrdy[k]) begin
        $display("inst%0d cyc%0d rsp id=%0d data=%0d err=%0d", k, c, rid[k], rdat[k], rerr[k]);
        m_busy[k] = 0;
        m_last[k] = m_id[k];
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) step(k);
  end

  task automatic set_req(input int k, input int ch, input logic v, input logic [3:0] x,
                         input logic [3:0] y, input logic s);
    if (ch == 0) begin
      v0[k] = v; x0[k] = x; y0[k] = y; s0[k] = s;
    end else begin
      v1[k] = v; x1[k] = x; y1[k] = y; s1[k] = s;
    end
  endtask

  function automatic logic rdy_of(input int k, input int ch);
    return (ch == 0) ? r0[k] : r1[k];
  endfunction

  // Called at #1 after a rising edge with the instance idle.
  task automatic do_op(input int k, input int ch, input logic [3:0] x, input logic [3:0] y,
                       input logic sub, input int hold, input int ed, input int ee,
                       input int elat);
    int t0;
    int n;
    rrdy[k] = (hold == 0);
    set_req(k, ch, 1'b1, x, y, sub);
    n = 0;
    @(negedge clk);
    while (!rdy_of(k, ch) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", k, n, 0);
    t0 = cyc;
    @(posedge clk); #1;
    set_req(k, ch, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
    @(negedge clk);
    chk("issue_after_accept", k, iss[k], (ee != 0) ? 0 : 1);
    chk("latched_x", k, dx[k], x);
    chk("latched_y", k, dy[k], y);
    chk("latched_s", k, ds[k], sub);
    n = 0;
    while (!rv[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", k, cyc - t0, elat);
    chk("lit_rsp_data", k, rdat[k], ed);
    chk("lit_rsp_err", k, rerr[k], ee);
    chk("lit_rsp_id", k, rid[k], ch);
    $display("inst%0d op ch=%0d x=%0d y=%0d sub=%0d -> data=%0d err=%0d", k, ch, x, y, sub,
             rdat[k], rerr[k]);
    if (hold > 0) begin
      repeat (hold - 1) @(negedge clk);
      chk("held_valid", k, rv[k], 1);
      chk("held_data", k, rdat[k], ed);
      @(posedge clk); #1;
      rrdy[k] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int i;
    int n;
    rst_b = 2'b11;
    for (int k = 0; k < 2; k++) begin
      v0[k] = 0; v1[k] = 0; x0[k] = 0; y0[k] = 0; x1[k] = 0; y1[k] = 0;
      s0[k] = 0; s1[k] = 0; rrdy[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_b = 2'b00;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_rsp_valid", k, rv[k], 0);
      chk("rst_rsp_data", k, rdat[k], 0);
      chk("rst_rsp_id", k, rid[k], 0);
      chk("rst_dp_issue", k, iss[k], 0);
      chk("rst_dp_x", k, dx[k], 0);
    end
    @(posedge clk); #1;

    do_op(0, 0, 4'd9, 4'd7, 1'b0, 0, 3, 0, 4);
    do_op(0, 1, 4'd2, 4'd5, 1'b1, 0, 10, 0, 4);
    do_op(0, 1, 4'd0, 4'd0, 1'b1, 0, 0, 0, 4);
    do_op(0, 0, 4'd13, 4'd1, 1'b0, 0, 0, 1, 1);
    do_op(0, 0, 4'd2, 4'd15, 1'b0, 0, 0, 1, 1);
    do_op(0, 1, 4'd12, 4'd12, 1'b0, 0, 11, 0, 4);
    do_op(0, 0, 4'd5, 4'd6, 1'b0, 5, 11, 0, 4);
    do_op(0, 1, 4'd1, 4'd3, 1'b1, 0, 11, 0, 4);

    // Abort an operation while it waits on the datapath.
    rrdy[0] = 1'b1;
    set_req(0, 0, 1'b1, 4'd9, 4'd7, 1'b0);
    @(posedge clk); #1;
    set_req(0, 0, 1'b0, 4'd0, 4'd0, 1'b0);
    @(posedge clk); #1;
    rst_b[0] = 1'b1;
    @(posedge clk); #1;
    rst_b[0] = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", 0, rv[0], 0);
    chk("abort_dp_issue", 0, iss[0], 0);
    chk("abort_dp_x", 0, dx[0], 0);
    chk("abort_dp_y", 0, dy[0], 0);
    chk("abort_rsp_data", 0, rdat[0], 0);
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_rsp", 0, rv[0], 0);
    end
    @(posedge clk); #1;
    do_op(0, 1, 4'd3, 4'd4, 1'b0, 0, 7, 0, 4);

    // Both channels request continuously on instance 1.
    rrdy[1] = 1'b1;
    set_req(1, 0, 1'b1, 4'd3, 4'd4, 1'b0);
    set_req(1, 1, 1'b1, 4'd10, 4'd9, 1'b1);
    i = 0;
    n = 0;
    while (i < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (r0[1] | r1[1]) begin
        chk("arb_grant", 1, r1[1], i % 2);
        i++;
      end
    end
    chk("arb_count", 1, i, 4);
    @(posedge clk); #1;
    set_req(1, 0, 1'b0, 4'd0, 4'd0, 1'b0);
    set_req(1, 1, 1'b0, 4'd0, 4'd0, 1'b0);
    repeat (12) @(posedge clk);
    #1;

    for (int it = 0; it < 2000; it++) begin
      for (int k = 0; k < 2; k++) begin
        rst_b[k] = ($urandom_range(0, 199) == 0);
        set_req(k, 0, ($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom), 1'($urandom));
        set_req(k, 1, ($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom), 1'($urandom));
        rrdy[k] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
    end
    rst_b = 2'b00;
    for (int k = 0; k < 2; k++) begin
      v0[k] = 0; v1[k] = 0; rrdy[k] = 1;
    end
    repeat (20) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
